// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state enum, default parameters and checksum seed.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_TIMEOUT = 50000;
  localparam logic [7:0] CHECK_XOR_INIT = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/loader_timer.sv
// Idle-cycle watchdog for the loader byte stream.
// Ports: clk, rst, clear, enable in; expired out (fires on the edge reaching TIMEOUT).
module loader_timer
  import imem_loader_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority, so a byte arriving on the final cycle cancels the timeout.
  assign expired = enable && !clear &&
                   (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program image into IMEM while holding the CPU.
// Ports: SYS_clk/SYS_rst, load_start/load_base, byte_valid/ready/data in,
// imem_we/addr/wdata out, cpu_hold, done, err, words_loaded status.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              SYS_clk,
  input  logic              SYS_rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [7:0]        words_loaded
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] words_q, words_d;
  logic [7:0] csum_q, csum_d;
  logic [1:0] idx_q, idx_d;

  logic accept;
  logic enter_hdr;
  logic expired;

  assign byte_ready = (state_q == S_HEADER) ||
                      (state_q == S_RECV) ||
                      (state_q == S_CHECK);
  assign accept = byte_valid && byte_ready;

  assign imem_we = (state_q == S_WRITE);
  assign imem_addr = addr_q;
  assign imem_wdata = word_q;
  assign cpu_hold = (state_q != S_IDLE) &&
                    (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign err = (state_q == S_ERROR);
  assign words_loaded = words_q;

  loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (SYS_clk),
    .rst    (SYS_rst),
    .clear  (enter_hdr || accept),
    .enable (byte_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    word_d = word_q;
    rem_d = rem_q;
    words_d = words_q;
    csum_d = csum_q;
    idx_d = idx_q;
    enter_hdr = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          enter_hdr = 1'b1;
          state_d = S_HEADER;
          addr_d = load_base;
          words_d = '0;
          csum_d = CHECK_XOR_INIT;
          idx_d = '0;
        end
      end
      S_HEADER: begin
        if (accept) begin
          rem_d = byte_data;
          csum_d = csum_q ^ byte_data;
          state_d = (byte_data == 8'd0) ? S_ERROR : S_RECV;
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      S_RECV: begin
        if (accept) begin
          word_d = {word_q[23:0], byte_data};
          csum_d = csum_q ^ byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        words_d = words_q + 8'd1;
        rem_d = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      word_q <= '0;
      rem_q <= '0;
      words_q <= '0;
      csum_q <= CHECK_XOR_INIT;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      word_q <= word_d;
      rem_q <= rem_d;
      words_q <= words_d;
      csum_q <= csum_d;
      idx_q <= idx_d;
    end
  end

endmodule
